// File: rtl/pic_prog_mem.sv
// pic_prog_mem: loadable program memory for the PIC core.
// Registered fetch port, valid/ready load port, self-clear after reset.
module pic_prog_mem #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 12,
  parameter int DEPTH  = 512
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Fetch_En,
  input  logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Data,
  output logic              Data_Valid,
  input  logic              Load_Start,
  input  logic              Load_Valid,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              Load_Last,
  output logic              Load_Ready,
  output logic [ADDR_W:0]   Load_Count,
  output logic              Load_Err,
  output logic              Busy
);

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C =
    ADDR_W'(DEPTH - 1);

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              xfer;
  logic              at_end;
  logic              fetch;
  logic              in_range;
  logic              start;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;

  assign xfer     = (state == LOAD) && Load_Valid;
  assign at_end   = (ptr == LAST_C);
  assign fetch    = (state == IDLE) && Fetch_En;
  assign start    = (state == IDLE) && Load_Start;
  assign in_range = ({1'b0, Addr} < DEPTH_C);

  assign Load_Ready = (state == LOAD);
  assign Busy       = (state != IDLE);

  // State register; reset restarts the erase pass.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= CLEAR;
    else          state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      CLEAR: if (at_end) state_nx = IDLE;
      IDLE:  if (Load_Start) state_nx = LOAD;
      LOAD:  if (xfer && (Load_Last || at_end))
               state_nx = IDLE;
      default: state_nx = CLEAR;
    endcase
  end

  // Array write source: zero while erasing, load word otherwise.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    unique case (1'b1)
      (state == CLEAR): wr_en = 1'b1;
      xfer: begin
        wr_en   = 1'b1;
        wr_data = Load_Data;
      end
      default: ;
    endcase
  end

  // Shared erase/load pointer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                     ptr <= '0;
    else if (start)                   ptr <= '0;
    else if (state == CLEAR || xfer)  ptr <= ptr + 1'b1;
  end

  // Storage array; contents are only cleared by the erase pass.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[ptr] <= wr_data;
  end

  // Registered fetch port; out-of-range reads return NOP.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Data       <= '0;
      Data_Valid <= 1'b0;
    end else begin
      Data_Valid <= fetch;
      if (fetch) Data <= in_range ? mem[Addr] : '0;
    end
  end

  // Load statistics, held until the next load starts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Load_Count <= '0;
      Load_Err   <= 1'b0;
    end else if (start) begin
      Load_Count <= '0;
      Load_Err   <= 1'b0;
    end else if (xfer) begin
      if (Load_Count != DEPTH_C)
        Load_Count <= Load_Count + 1'b1;
      if (at_end && !Load_Last)
        Load_Err <= 1'b1;
    end
  end

endmodule

// File: doc/pic_prog_mem.md
# pic_prog_mem

Parametrised, loadable program memory for the PIC core: the next generation of the fixed combinational instruction ROM. It provides a registered instruction-fetch port with one-cycle latency and a valid/ready load port that writes a program image into the array at run time. After reset it self-clears the array, so unloaded locations read as the NOP word 0. It sits between the program counter and the instruction register, and is fed by a boot loader or testbench.

## Interface
- ADDR_W, 9, fetch/load address width
- DATA_W, 12, instruction word width
- DEPTH, 512, number of words; must satisfy 1 <= DEPTH <= 2^ADDR_W
- Clk  in  1  single clock; all state changes on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Fetch_En  in  1  request a read of Addr this cycle
- Addr  in  ADDR_W  fetch address
- Data  out  DATA_W  registered instruction word
- Data_Valid  out  1  Data holds the result of a fetch accepted last cycle
- Load_Start  in  1  single-cycle pulse; begin loading at address 0
- Load_Valid  in  1  Load_Data is valid
- Load_Data  in  DATA_W  program word to write
- Load_Last  in  1  qualifies the final word of the image
- Load_Ready  out  1  block accepts a load word this cycle
- Load_Count  out  ADDR_W+1  words written by the current or last load
- Load_Err  out  1  sticky; image filled the array without Load_Last
- Busy  out  1  high in CLEAR or LOAD; fetches are not served

## Operation
- FSM states: CLEAR, IDLE, LOAD.
- Reset asserted: state goes to CLEAR and the clear pointer goes to 0.
  - Output reset values: Data=0, Data_Valid=0, Load_Ready=0, Load_Count=0, Load_Err=0, Busy=1.
  - Array contents are not reset directly; CLEAR erases them.
- CLEAR:
  - Writes 0 to mem[ptr] each cycle and increments ptr.
  - After the write to DEPTH-1, goes to IDLE.
  - Load_Start and Fetch_En are ignored.
- IDLE:
  - Busy=0, Load_Ready=0.
  - Fetch_En=1: Data <= mem[Addr], or 0 if Addr >= DEPTH; Data_Valid <= 1.
  - Fetch_En=0: Data holds its value; Data_Valid <= 0.
  - Load_Start=1: go to LOAD, ptr <= 0, Load_Count <= 0, Load_Err <= 0.
  - Load_Start with Fetch_En in the same cycle: the fetch is served (it returns pre-load contents), then the state changes.
- LOAD:
  - Load_Ready=1, Busy=1.
  - Transfer occurs when Load_Valid && Load_Ready: mem[ptr] <= Load_Data, ptr++, Load_Count++.
  - A transfer with Load_Last=1 goes to IDLE.
  - A transfer at ptr=DEPTH-1 also goes to IDLE. If that word lacks Load_Last, Load_Err <= 1.
  - Fetch_En is ignored: Data_Valid=0 and Data holds.
  - Load_Start is ignored.
- A fetch of an address that was never loaded since reset returns 0. Locations beyond the loaded image keep their previous contents.
- Load_Count saturates at DEPTH; Load_Count and Load_Err hold until the next Load_Start or reset.
- Reset mid-load: abort immediately, return to CLEAR, and erase the partial image.

## Timing
- Fetch latency is 1 cycle: Addr is sampled at edge N; Data/Data_Valid are valid after edge N.
- Back-to-back fetches sustain 1 word per cycle.
- Load throughput is 1 word per cycle while Load_Valid is held high.
- Load_Ready is a function of state only; it does not depend on Load_Valid.
- CLEAR lasts exactly DEPTH cycles after reset deassertion; Busy falls at the edge that enters IDLE.
- Sequence Load_Start → LOAD: Load_Ready rises at the next edge. The last transfer → IDLE: Load_Ready falls at the same edge that writes the last word. A fetch may be issued at the first IDLE cycle and returns the new word.
- Write-then-read of the same address: a fetch in the cycle after the write returns the new value. There is no read-during-write case, because fetches are blocked while loading.

## Test plan
- Reset then wait for clear: release Reset_n, count cycles → Busy high for exactly DEPTH=512 cycles. Then Fetch_En with Addr=0, 100, 511 → Data=0x000 and Data_Valid=1 one cycle later.
- Load and fetch: Load_Start, stream 49 words 0xC09, 0x028, … with Load_Last on word 48 → Load_Count=49, Load_Err=0, IDLE. Fetch addresses 0..48 back-to-back → each word returned 1 cycle after its address; Addr=49 → 0x000.
- Backpressure and bubbles: toggle Load_Valid 1,0,1,1,0 with data 0xAAA, 0xBBB, 0xCCC → only valid cycles are written (mem[0..2]=AAA, BBB, CCC) and Load_Count=3.
- Overflow: DEPTH=8, load 8 words without Load_Last → returns to IDLE after word 8, Load_Err=1, Load_Count=8. A 9th Load_Valid is not accepted (Load_Ready=0).
- Out-of-range and blocking: DEPTH=8, ADDR_W=4, fetch Addr=12 → Data=0. Fetch_En during LOAD → Data_Valid=0 and Data unchanged. Load_Start coincident with a fetch in IDLE → old word returned, then Load_Ready=1.
- Reset mid-load: assert Reset_n low after 5 words → outputs return to reset values immediately. After CLEAR completes, fetch of addresses 0..4 → 0x000.
